// File: rtl/io_responder.sv
// CPU-bus I/O responder: 2 KiB mirrored RAM plus serial controller ports at $4016/$4017.
// Define SECOND_PAD_EN to build the second controller port; otherwise $4017 reads 8'h40.
module io_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        rw,
    input  logic [15:0] addr,
    inout  wire  [7:0]  data,
    input  logic [7:0]  pad1_buttons,
`ifdef SECOND_PAD_EN
    input  logic [7:0]  pad2_buttons,
`endif
    output logic        hit
);
    logic [7:0] r_mem [0:2047];
    logic [7:0] r_rd_data;
    logic       r_drive;
    logic       r_hit;
    logic       r_arm;
    logic       r_strobe;
    logic [7:0] r_sr1;

    logic       w_ram_sel;
    logic       w_p1_sel;
    logic       w_p2_sel;
    logic       w_dec;
    logic       w_rd;
    logic       w_wr;
    logic [7:0] w_p1_byte;
    logic [7:0] w_p2_byte;

    assign w_ram_sel = (addr[15:13] == 3'b000);
    assign w_p1_sel  = (addr == 16'h4016);
    assign w_p2_sel  = (addr == 16'h4017);
    // r_arm drops the first edge after reset release so a half-set-up access is not honored
    assign w_dec     = r_arm & (w_ram_sel | w_p1_sel | w_p2_sel);
    assign w_rd      = w_dec & rw;
    assign w_wr      = w_dec & ~rw;

    // Upper bits 3'b010 mimic the open-bus value the CPU sees on controller reads
    assign w_p1_byte = {3'b010, 4'b0000, r_strobe ? pad1_buttons[0] : r_sr1[0]};

`ifdef SECOND_PAD_EN
    logic [7:0] r_sr2;
    assign w_p2_byte = {3'b010, 4'b0000, r_strobe ? pad2_buttons[0] : r_sr2[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr2 <= 8'hFF;
        end else if (r_strobe) begin
            r_sr2 <= pad2_buttons;
        end else if (w_rd && w_p2_sel) begin
            r_sr2 <= {1'b1, r_sr2[7:1]};
        end
    end
`else
    assign w_p2_byte = 8'h40;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arm    <= 1'b0;
            r_strobe <= 1'b0;
            r_sr1    <= 8'hFF;
            r_hit    <= 1'b0;
            r_drive  <= 1'b0;
        end else begin
            r_arm   <= 1'b1;
            r_hit   <= w_dec;
            r_drive <= w_rd;
            // Reload uses the pre-edge strobe, so a 1->0 write still captures this edge's buttons
            if (r_strobe) begin
                r_sr1 <= pad1_buttons;
            end else if (w_rd && w_p1_sel) begin
                r_sr1 <= {1'b1, r_sr1[7:1]};
            end
            if (w_wr && w_p1_sel) begin
                r_strobe <= data[0];
            end
        end
    end

    // RAM and read-data holding register carry no reset; r_drive qualifies the bus
    always_ff @(posedge clk) begin
        if (w_wr && w_ram_sel) begin
            r_mem[addr[10:0]] <= data;
        end
        if (w_rd) begin
            if (w_ram_sel) begin
                r_rd_data <= r_mem[addr[10:0]];
            end else if (w_p1_sel) begin
                r_rd_data <= w_p1_byte;
            end else begin
                r_rd_data <= w_p2_byte;
            end
        end
    end

    assign data = r_drive ? r_rd_data : 8'hzz;
    assign hit  = r_hit;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed bus scenarios then random traffic against a
// transaction-level model (RAM array, strobe flag, latched button byte + read index).
module tb_io_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic [15:0] addr;
    wire  [7:0]  data;
    logic [7:0]  pad1;
    logic [7:0]  pad2;
    logic        hit;
    logic [7:0]  tb_d;
    logic        tb_oe;

    int checks   = 0;
    int failures = 0;

    assign data = tb_oe ? tb_d : 8'hzz;

    // Undriven bus floats to 8'hFF, which makes high-Z observable as a value
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data[g]);
    end

    io_responder dut (
        .clk          (clk),
        .rst          (rst),
        .rw           (rw),
        .addr         (addr),
        .data         (data),
        .pad1_buttons (pad1),
`ifdef SECOND_PAD_EN
        .pad2_buttons (pad2),
`endif
        .hit          (hit)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_ram [0:2047];
    bit         m_strobe;
    bit         m_arm;
    logic [7:0] m_lat1, m_lat2;
    int         m_idx1, m_idx2;
    bit         last_rd;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    function automatic logic pad_bit(input logic [7:0] lat, input int idx);
        return (idx < 8) ? lat[idx] : 1'b1;
    endfunction

    // One bus cycle: drive after the falling edge, model the rising edge, check at the next falling edge
    task automatic step(input logic r, input logic [15:0] a, input logic [7:0] wd, input string tag);
        logic [7:0] exp_d;
        logic       exp_hit;
        bit         old_s;
        rw    = r;
        addr  = a;
        tb_d  = wd;
        tb_oe = !r;
        @(posedge clk);
        old_s   = m_strobe;
        exp_hit = 1'b0;
        exp_d   = 8'hFF;
        if (!m_arm) begin
            m_arm = 1'b1;
        end else begin
            if (a[15:13] == 3'b000) begin
                exp_hit = 1'b1;
                if (r) exp_d = m_ram[a[10:0]];
                else   m_ram[a[10:0]] = wd;
            end else if (a == 16'h4016) begin
                exp_hit = 1'b1;
                if (r) begin
                    exp_d = {7'b0100000, old_s ? pad1[0] : pad_bit(m_lat1, m_idx1)};
                    if (!old_s && m_idx1 < 8) m_idx1++;
                end else begin
                    m_strobe = wd[0];
                end
            end else if (a == 16'h4017) begin
                exp_hit = 1'b1;
                if (r) begin
`ifdef SECOND_PAD_EN
                    exp_d = {7'b0100000, old_s ? pad2[0] : pad_bit(m_lat2, m_idx2)};
                    if (!old_s && m_idx2 < 8) m_idx2++;
`else
                    exp_d = 8'h40;
`endif
                end
            end
            if (old_s) begin
                m_lat1 = pad1; m_idx1 = 0;
                m_lat2 = pad2; m_idx2 = 0;
            end
        end
        last_rd = r && exp_hit;
        @(negedge clk);
        tb_oe = 1'b0;
        #1;
        check({tag, ".hit"}, {7'b0, hit}, {7'b0, exp_hit});
        check({tag, ".data"}, data, exp_d);
    endtask

    // Writes after a driven read get an idle cycle so the bus turns around cleanly
    task automatic acc(input logic r, input logic [15:0] a, input logic [7:0] wd, input string tag);
        if (!r && last_rd) step(1'b1, 16'h3000, 8'h00, "idle");
        step(r, a, wd, tag);
    endtask

    task automatic model_reset();
        m_strobe = 1'b0;
        m_arm    = 1'b0;
        m_lat1   = 8'hFF; m_idx1 = 0;
        m_lat2   = 8'hFF; m_idx2 = 0;
        last_rd  = 1'b0;
    endtask

    logic [8:0] seq = 9'b1_1000_0101; // expected bit0 per read, read 0 in bit 0
    int         op;
    logic [15:0] ra;

    initial begin
        rst = 1'b1; rw = 1'b1; addr = 16'h3000; tb_d = 8'h00; tb_oe = 1'b0;
        pad1 = 8'h00; pad2 = 8'h00;
        model_reset();
        #1;
        check("reset.hit", {7'b0, hit}, 8'h00);
        check("reset.data", data, 8'hFF);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        step(1'b1, 16'h4016, 8'h00, "rel_ignored");

        // RAM write then mirrored read
        acc(1'b0, 16'h0123, 8'hA5, "ram_wr");
        acc(1'b1, 16'h0923, 8'h00, "ram_mirror");
        check("ram_mirror.const", data, 8'hA5);

        // Serial readout of a latched pattern, then the exhausted value
        pad1 = 8'b1000_0101;
        acc(1'b0, 16'h4016, 8'h01, "strobe1");
        acc(1'b0, 16'h4016, 8'h00, "strobe0");
        pad1 = 8'h00;
        for (int i = 0; i < 9; i++) begin
            acc(1'b1, 16'h4016, 8'h00, "p1_seq");
            check("p1_seq.const", data, {7'b0100000, seq[i]});
        end

        // Strobe held high: live bit A, no shift
        acc(1'b0, 16'h4016, 8'h01, "strobe_hold");
        pad1 = 8'h00;
        acc(1'b1, 16'h4016, 8'h00, "live0");
        check("live0.const", data, 8'h40);
        pad1 = 8'h01;
        acc(1'b1, 16'h4016, 8'h00, "live1");
        check("live1.const", data, 8'h41);

        // Reset in the middle of a readout
        pad1 = 8'b0101_0110;
        acc(1'b0, 16'h4016, 8'h00, "strobe_lo");
        pad1 = 8'h00;
        for (int i = 0; i < 3; i++) acc(1'b1, 16'h4016, 8'h00, "pre_rst");
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("rst_async.data", data, 8'hFF);
        check("rst_async.hit", {7'b0, hit}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        step(1'b0, 16'h0123, 8'h5A, "rst_ignored_wr");
        acc(1'b1, 16'h4016, 8'h00, "post_rst_pad");
        check("post_rst_pad.const", data, 8'h41);
        acc(1'b1, 16'h0123, 8'h00, "post_rst_ram");
        check("post_rst_ram.const", data, 8'hA5);

        // Second port and a no-decode access
        pad2 = 8'h01;
        acc(1'b0, 16'h4016, 8'h01, "p2_strobe1");
        acc(1'b0, 16'h4016, 8'h00, "p2_strobe0");
        acc(1'b1, 16'h4017, 8'h00, "p2_read");
`ifdef SECOND_PAD_EN
        check("p2_read.const", data, 8'h41);
`else
        check("p2_read.const", data, 8'h40);
`endif
        acc(1'b1, 16'h5000, 8'h00, "nodecode");
        check("nodecode.hit", {7'b0, hit}, 8'h00);

        // Random traffic over a preloaded RAM window (and its mirrors)
        for (int i = 0; i < 64; i++) acc(1'b0, 16'(i), 8'($urandom_range(0, 254)), "preload");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pad1 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pad2 = 8'($urandom);
            op = $urandom_range(0, 7);
            ra = (16'($urandom_range(0, 3)) << 11) | 16'($urandom_range(0, 63));
            case (op)
                0:       acc(1'b0, ra, 8'($urandom_range(0, 254)), "rnd_ram_wr");
                1, 2:    acc(1'b1, ra, 8'h00, "rnd_ram_rd");
                3:       acc(1'b0, 16'h4016, {7'b0, $urandom_range(0, 3) == 0}, "rnd_strobe");
                4:       acc(1'b1, 16'h4016, 8'h00, "rnd_p1");
                5:       acc(1'b1, 16'h4017, 8'h00, "rnd_p2");
                6:       acc(1'b0, 16'h4017, 8'($urandom), "rnd_p2_wr");
                default: acc(1'($urandom_range(0, 1)), 16'h2000 + 16'($urandom_range(0, 16'h1FFF)),
                             8'($urandom_range(0, 254)), "rnd_nodec");
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
